// File: rtl/tc_multi_if.sv
// Bus bundle between the memory-stage data bridge and tc_multi.
// The bridge side is master; the timer block is slave.
interface tc_multi_if #(
   parameter int CHANNELS = 2,
   parameter int AW       = $clog2(CHANNELS) + 2
);
   logic [AW-1:0]       addr;
   logic                we;
   logic [31:0]         wdata;
   logic [31:0]         rdata;
   logic [CHANNELS-1:0] irq;
   logic                irq_any;

   modport master (
      output addr, we, wdata,
      input  rdata, irq, irq_any
   );

   modport slave (
      input  addr, we, wdata,
      output rdata, irq, irq_any
   );
endinterface

// File: rtl/tc_multi.sv
// Multi-channel down-counting timer with per-channel prescaler,
// one-shot/auto-reload modes and sticky W1C interrupt status.
module tc_multi #(
   parameter int CHANNELS = 2,
   parameter int WIDTH    = 32,
   parameter int AW       = $clog2(CHANNELS) + 2
) (
   input logic       clk,
   input logic       reset,
   tc_multi_if.slave bus
);
   localparam int CIW = AW - 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_COUNT,
      S_INT
   } state_t;

   state_t              st     [CHANNELS];
   logic [11:0]         ctrl   [CHANNELS];
   logic [WIDTH-1:0]    preset [CHANNELS];
   logic [WIDTH-1:0]    cnt    [CHANNELS];
   logic [7:0]          psc    [CHANNELS];
   logic [CHANNELS-1:0] pend;

   logic [AW:0]         a_ext;
   logic [CIW-1:0]      ch_idx;
   logic [1:0]          reg_sel;
   logic [CHANNELS-1:0] sel;
   logic [CHANNELS-1:0] wr_ctrl;
   logic [CHANNELS-1:0] wr_pre;
   logic [CHANNELS-1:0] w1c;
   logic [CHANNELS-1:0] irq_v;

   // Padding keeps the channel field at least one bit wide when CHANNELS == 1.
   assign a_ext   = {1'b0, bus.addr};
   assign ch_idx  = a_ext[AW:2];
   assign reg_sel = bus.addr[1:0];

   always_comb begin
      sel     = '0;
      wr_ctrl = '0;
      wr_pre  = '0;
      w1c     = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         sel[i]     = (ch_idx == CIW'(i));
         wr_ctrl[i] = sel[i] & bus.we & (reg_sel == 2'd0);
         wr_pre[i]  = sel[i] & bus.we & (reg_sel == 2'd1);
         w1c[i]     = sel[i] & bus.we & (reg_sel == 2'd3) & bus.wdata[0];
      end
   end

   always_comb begin
      bus.rdata = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (sel[i]) begin
            case (reg_sel)
               2'd0: bus.rdata = {20'd0, ctrl[i]};
               2'd1: bus.rdata = 32'(preset[i]);
               2'd2: bus.rdata = 32'(cnt[i]);
               2'd3: bus.rdata = {31'd0, pend[i]};
            endcase
         end
      end
   end

   always_comb begin
      irq_v = '0;
      for (int i = 0; i < CHANNELS; i++)
         irq_v[i] = pend[i] & ctrl[i][3];
   end

   assign bus.irq     = irq_v;
   assign bus.irq_any = |irq_v;

   // Bus writes come after the FSM so a CTRL write overrides the EN auto-clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < CHANNELS; i++) begin
            st[i]     <= S_IDLE;
            ctrl[i]   <= '0;
            preset[i] <= '0;
            cnt[i]    <= '0;
            psc[i]    <= '0;
            pend[i]   <= 1'b0;
         end
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (w1c[i])
               pend[i] <= 1'b0;
            if (wr_ctrl[i] && !bus.wdata[0]) begin
               st[i] <= S_IDLE;
            end else begin
               unique case (st[i])
                  S_IDLE: begin
                     if (ctrl[i][0])
                        st[i] <= S_LOAD;
                  end
                  S_LOAD: begin
                     cnt[i] <= preset[i];
                     psc[i] <= '0;
                     st[i]  <= S_COUNT;
                  end
                  S_COUNT: begin
                     if (!ctrl[i][0]) begin
                        st[i] <= S_IDLE;
                     end else if (cnt[i] == '0) begin
                        st[i]   <= S_INT;
                        pend[i] <= 1'b1;
                     end else if (psc[i] == ctrl[i][11:4]) begin
                        psc[i] <= '0;
                        cnt[i] <= cnt[i] - 1'b1;
                     end else begin
                        psc[i] <= psc[i] + 1'b1;
                     end
                  end
                  S_INT: begin
                     if (ctrl[i][2:1] == 2'b01 && ctrl[i][0]) begin
                        st[i] <= S_LOAD;
                     end else begin
                        st[i]      <= S_IDLE;
                        ctrl[i][0] <= 1'b0;
                     end
                  end
               endcase
            end
            if (wr_ctrl[i])
               ctrl[i] <= bus.wdata[11:0];
            if (wr_pre[i])
               preset[i] <= bus.wdata[WIDTH-1:0];
         end
      end
   end
endmodule

// File: tb/tb_tc_multi.sv
// Self-checking bench for tc_multi: directed scenarios plus randomized
// one-shot runs checked against closed-form expiry times.
module tb_tc_multi;
   localparam int CH = 3;
   localparam int W  = 16;
   localparam int AW = 4;

   logic clk;
   logic reset;
   int   errors;
   int   checks;

   tc_multi_if #(.CHANNELS(CH), .AW(AW)) bus ();

   tc_multi #(
      .CHANNELS(CH),
      .WIDTH   (W),
      .AW      (AW)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr(input int ch, input int r, input logic [31:0] d);
      bus.addr  = AW'(ch * 4 + r);
      bus.wdata = d;
      bus.we    = 1'b1;
      @(posedge clk);
      #1;
      bus.we    = 1'b0;
   endtask

   task automatic peek(input int ch, input int r, output logic [31:0] d);
      bus.addr = AW'(ch * 4 + r);
      #1;
      d = bus.rdata;
   endtask

   task automatic rd(input int ch, input int r, output logic [31:0] d);
      peek(ch, r, d);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      logic [31:0] d;
      reset = 1'b1;
      step(2);
      reset = 1'b0;
      for (int a = 0; a < 16; a++) begin
         rd(a / 4, a % 4, d);
         checks++;
         if (d !== 32'd0) begin
            errors++;
            $display("FAIL reset_rdata a=%0d got=%h want=0", a, d);
         end
      end
      checks++;
      if (bus.irq !== 3'b000 || bus.irq_any !== 1'b0) begin
         errors++;
         $display("FAIL reset_irq got=%b/%b want=000/0", bus.irq, bus.irq_any);
      end
   endtask

   task automatic test_oneshot;
      logic [31:0] d;
      wr(0, 1, 32'd5);
      wr(0, 0, 32'h009);
      step(7);
      checks++;
      if (bus.irq[0] !== 1'b0) begin
         errors++;
         $display("FAIL oneshot_early got=%b want=0", bus.irq[0]);
      end
      step(1);
      checks++;
      if (bus.irq[0] !== 1'b1) begin
         errors++;
         $display("FAIL oneshot_irq got=%b want=1", bus.irq[0]);
      end
      step(1);
      peek(0, 0, d);
      checks++;
      if (d !== 32'h008) begin
         errors++;
         $display("FAIL oneshot_ctrl got=%h want=008", d);
      end
      peek(0, 2, d);
      checks++;
      if (d !== 32'd0) begin
         errors++;
         $display("FAIL oneshot_count got=%h want=0", d);
      end
      wr(0, 3, 32'd1);
      checks++;
      if (bus.irq[0] !== 1'b0) begin
         errors++;
         $display("FAIL oneshot_w1c got=%b want=0", bus.irq[0]);
      end
   endtask

   task automatic test_autoreload;
      int cur;
      wr(1, 1, 32'd3);
      wr(1, 0, 32'h01B);
      cur = 0;
      for (int k = 1; k <= 3; k++) begin
         step(9 * k - 1 - cur);
         checks++;
         if (bus.irq[1] !== 1'b0) begin
            errors++;
            $display("FAIL reload_early k=%0d got=%b want=0", k, bus.irq[1]);
         end
         step(1);
         checks++;
         if (bus.irq[1] !== 1'b1 || bus.irq_any !== 1'b1) begin
            errors++;
            $display("FAIL reload_irq k=%0d got=%b/%b want=1/1",
                     k, bus.irq[1], bus.irq_any);
         end
         wr(1, 3, 32'd1);
         cur = 9 * k + 1;
      end
      wr(1, 0, 32'h0);
      wr(1, 3, 32'd1);
      checks++;
      if (bus.irq_any !== 1'b0) begin
         errors++;
         $display("FAIL reload_stop got=%b want=0", bus.irq_any);
      end
   endtask

   task automatic test_disable_rewrite;
      logic [31:0] d;
      wr(0, 1, 32'd10);
      wr(0, 0, 32'h009);
      step(6);
      peek(0, 2, d);
      checks++;
      if (d !== 32'd6) begin
         errors++;
         $display("FAIL midcount_count got=%0d want=6", d);
      end
      wr(0, 0, 32'h0);
      step(2);
      peek(0, 2, d);
      checks++;
      if (d !== 32'd6) begin
         errors++;
         $display("FAIL disable_hold got=%0d want=6", d);
      end
      wr(0, 1, 32'd2);
      peek(0, 2, d);
      checks++;
      if (d !== 32'd6) begin
         errors++;
         $display("FAIL preset_no_touch got=%0d want=6", d);
      end
      wr(0, 0, 32'h009);
      step(4);
      checks++;
      if (bus.irq[0] !== 1'b0) begin
         errors++;
         $display("FAIL reenable_early got=%b want=0", bus.irq[0]);
      end
      step(1);
      checks++;
      if (bus.irq[0] !== 1'b1) begin
         errors++;
         $display("FAIL reenable_irq got=%b want=1", bus.irq[0]);
      end
      wr(0, 3, 32'd1);
   endtask

   task automatic test_edges;
      logic [31:0] d;
      wr(2, 1, 32'd0);
      wr(2, 0, 32'h009);
      step(2);
      checks++;
      if (bus.irq[2] !== 1'b0) begin
         errors++;
         $display("FAIL p0_early got=%b want=0", bus.irq[2]);
      end
      step(1);
      checks++;
      if (bus.irq[2] !== 1'b1) begin
         errors++;
         $display("FAIL p0_irq got=%b want=1", bus.irq[2]);
      end
      wr(2, 3, 32'd1);
      wr(2, 1, 32'd2);
      wr(2, 0, 32'h009);
      step(4);
      wr(2, 3, 32'd1);
      peek(2, 3, d);
      checks++;
      if (d !== 32'd1) begin
         errors++;
         $display("FAIL w1c_vs_set got=%0d want=1", d);
      end
      step(1);
      wr(2, 3, 32'd1);
      peek(2, 3, d);
      checks++;
      if (d !== 32'd0) begin
         errors++;
         $display("FAIL w1c_clear got=%0d want=0", d);
      end
      wr(1, 1, 32'd1);
      wr(1, 0, 32'h001);
      step(4);
      peek(1, 3, d);
      checks++;
      if (d !== 32'd1 || bus.irq[1] !== 1'b0 || bus.irq_any !== 1'b0) begin
         errors++;
         $display("FAIL masked got=pend%0d irq%b any%b want=pend1 irq0 any0",
                  d, bus.irq[1], bus.irq_any);
      end
      wr(1, 3, 32'd1);
      wr(0, 1, 32'd1);
      wr(0, 0, 32'h009);
      step(4);
      wr(0, 0, 32'h009);
      peek(0, 0, d);
      checks++;
      if (d !== 32'h009) begin
         errors++;
         $display("FAIL ctrl_wins got=%h want=009", d);
      end
      wr(0, 0, 32'h0);
      wr(0, 3, 32'd1);
      wr(3, 0, 32'h009);
      wr(3, 1, 32'd5);
      for (int r = 0; r < 4; r++) begin
         rd(3, r, d);
         checks++;
         if (d !== 32'd0) begin
            errors++;
            $display("FAIL oob_read r=%0d got=%h want=0", r, d);
         end
      end
      step(10);
      checks++;
      if (bus.irq_any !== 1'b0) begin
         errors++;
         $display("FAIL oob_side_effect got=%b want=0", bus.irq_any);
      end
      wr(2, 1, 32'hFFFF_1234);
      peek(2, 1, d);
      checks++;
      if (d !== 32'h0000_1234) begin
         errors++;
         $display("FAIL preset_zext got=%h want=00001234", d);
      end
      wr(2, 0, 32'hABCD_E5F0);
      peek(2, 0, d);
      checks++;
      if (d !== 32'h0000_05F0) begin
         errors++;
         $display("FAIL ctrl_mask got=%h want=000005f0", d);
      end
      wr(2, 0, 32'h0);
      wr(2, 2, 32'h55);
      peek(2, 2, d);
      checks++;
      if (d !== 32'd0) begin
         errors++;
         $display("FAIL count_ro got=%h want=0", d);
      end
   endtask

   task automatic test_random;
      logic [31:0] d;
      logic [31:0] cv;
      int ch, p, ps, im, md, t;
      for (int n = 0; n < 8; n++) begin
         ch = $urandom_range(0, CH - 1);
         p  = $urandom_range(0, 12);
         ps = $urandom_range(0, 3);
         im = $urandom_range(0, 1);
         md = $urandom_range(0, 2);
         if (md == 1) md = 3;
         t  = 3 + p * (ps + 1);
         cv = 32'((ps << 4) | (im << 3) | (md << 1) | 1);
         wr(ch, 1, 32'(p));
         wr(ch, 0, cv);
         step(t - 1);
         peek(ch, 3, d);
         checks++;
         if (d !== 32'd0) begin
            errors++;
            $display("FAIL rnd_early n=%0d p=%0d ps=%0d got=%0d want=0",
                     n, p, ps, d);
         end
         step(1);
         peek(ch, 3, d);
         checks++;
         if (d !== 32'd1 || bus.irq[ch] !== im[0]) begin
            errors++;
            $display("FAIL rnd_expire n=%0d p=%0d ps=%0d got=%0d/%b want=1/%0d",
                     n, p, ps, d, bus.irq[ch], im);
         end
         step(1);
         peek(ch, 0, d);
         checks++;
         if (d !== (cv & 32'hFFE)) begin
            errors++;
            $display("FAIL rnd_ctrl n=%0d got=%h want=%h", n, d, cv & 32'hFFE);
         end
         wr(ch, 3, 32'd1);
         checks++;
         if (bus.irq !== 3'b000) begin
            errors++;
            $display("FAIL rnd_clear n=%0d got=%b want=000", n, bus.irq);
         end
      end
   endtask

   task automatic test_reset_mid;
      logic [31:0] d;
      wr(0, 1, 32'd8);
      wr(0, 0, 32'h009);
      step(6);
      peek(0, 2, d);
      checks++;
      if (d !== 32'd4) begin
         errors++;
         $display("FAIL rstmid_pre got=%0d want=4", d);
      end
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      peek(0, 0, d);
      checks++;
      if (d !== 32'd0) begin
         errors++;
         $display("FAIL rstmid_ctrl got=%h want=0", d);
      end
      peek(0, 2, d);
      checks++;
      if (d !== 32'd0 || bus.irq !== 3'b000) begin
         errors++;
         $display("FAIL rstmid_count got=%0d/%b want=0/000", d, bus.irq);
      end
      step(20);
      peek(0, 3, d);
      checks++;
      if (d !== 32'd0 || bus.irq_any !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_noexp got=%0d/%b want=0/0", d, bus.irq_any);
      end
   endtask

   initial begin
      errors    = 0;
      checks    = 0;
      reset     = 1'b1;
      bus.addr  = '0;
      bus.we    = 1'b0;
      bus.wdata = '0;
      test_reset;
      test_oneshot;
      test_autoreload;
      test_disable_rewrite;
      test_edges;
      test_random;
      test_reset_mid;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
